// File: rtl/alu_flag_sched_pkg.sv
// Shared types and constants for the EX-stage ALU/flag scheduler.
// Holds the {alu_op, func} decode points, ALU control encodings and FSM states.
package alu_flag_sched_pkg;

  localparam logic [3:0] OP_ADI_HI = 4'b0000;
  localparam logic [5:0] OP_ADD    = 6'b0001_00;
  localparam logic [5:0] OP_ADZ    = 6'b0001_01;
  localparam logic [5:0] OP_ADC    = 6'b0001_10;
  localparam logic [5:0] OP_ADL    = 6'b0001_11;
  localparam logic [5:0] OP_NDU    = 6'b0010_00;
  localparam logic [5:0] OP_NDZ    = 6'b0010_01;
  localparam logic [5:0] OP_NDC    = 6'b0010_10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NAND = 2'b01;
  localparam logic [1:0] ALU_NOP  = 2'b10;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LDPEND = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_ADD  = 2'd1,
    CLS_NAND = 2'd2
  } op_class_e;

  typedef struct packed {
    op_class_e cls;
    logic      reads_c;
    logic      reads_z;
    logic      writes_c;
    logic      writes_z;
  } dec_t;

  function automatic logic [1:0] class_ctrl(input op_class_e cls);
    case (cls)
      CLS_ADD:  return ALU_ADD;
      CLS_NAND: return ALU_NAND;
      default:  return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/alu_flag_sched_if.sv
// EX-stage bus between the ID/EX register, MEM load return and the scheduler.
// All signals are level, single-cycle qualified; there is no valid/ready pair here.
interface alu_flag_sched_if;
  import alu_flag_sched_pkg::*;

  logic       ex_valid;
  logic [3:0] ex_alu_op;
  logic [1:0] ex_func;
  logic       ex_is_load;
  logic       alu_carry;
  logic       alu_zero;
  logic       mem_ld_valid;
  logic       mem_ld_zero;
  logic       flush;
  logic [1:0] alu_ctrl;
  logic       ex_commit;
  logic       ex_stall;
  logic       carry_q;
  logic       zero_q;
  logic       ld_err;
  state_e     dbg_state;

  modport master (
    output ex_valid, ex_alu_op, ex_func, ex_is_load, alu_carry, alu_zero,
           mem_ld_valid, mem_ld_zero, flush,
    input  alu_ctrl, ex_commit, ex_stall, carry_q, zero_q, ld_err, dbg_state
  );

  modport slave (
    input  ex_valid, ex_alu_op, ex_func, ex_is_load, alu_carry, alu_zero,
           mem_ld_valid, mem_ld_zero, flush,
    output alu_ctrl, ex_commit, ex_stall, carry_q, zero_q, ld_err, dbg_state
  );

endinterface

// File: rtl/alu_flag_decode.sv
// Combinational decode of {alu_op, func} into op class and flag read/write masks.
module alu_flag_decode
  import alu_flag_sched_pkg::*;
(
    input  logic [3:0] alu_op,
    input  logic [1:0] func,
    output dec_t       dec
);

    always_comb begin
        dec     = '0;
        dec.cls = CLS_NONE;
        // ADI ignores the function field entirely.
        if (alu_op == OP_ADI_HI) begin
            dec.cls = CLS_ADD;
        end else begin
            case ({alu_op, func})
                OP_ADD, OP_ADL: dec.cls = CLS_ADD;
                OP_ADC: begin dec.cls = CLS_ADD;  dec.reads_c = 1'b1; end
                OP_ADZ: begin dec.cls = CLS_ADD;  dec.reads_z = 1'b1; end
                OP_NDU: dec.cls = CLS_NAND;
                OP_NDC: begin dec.cls = CLS_NAND; dec.reads_c = 1'b1; end
                OP_NDZ: begin dec.cls = CLS_NAND; dec.reads_z = 1'b1; end
                default: dec.cls = CLS_NONE;
            endcase
        end
        dec.writes_c = (dec.cls == CLS_ADD);
        dec.writes_z = (dec.cls != CLS_NONE);
    end

endmodule

// File: rtl/alu_flag_sched.sv
// EX-stage ALU/flag scheduler: decode, conditional resolve, C/Z flags, load-Z interlock.
// Optional perf counters are built when ALU_SCHED_PERF_EN is defined.
module alu_flag_sched
  import alu_flag_sched_pkg::*;
#(
    parameter int LD_TIMEOUT = 15,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef ALU_SCHED_PERF_EN
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_skip_cnt,
`endif
    alu_flag_sched_if.slave   bus
);

    localparam int TW = $clog2(LD_TIMEOUT + 1);

    dec_t          dec;
    state_e        state_q, state_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          carry_q, carry_d;
    logic          zero_q, zero_d;
    logic          ld_err_q, ld_err_d;
    logic [1:0]    alu_ctrl;
    logic          ex_commit, ex_stall, ld_start, skip, cond_ok, in_ld;

    alu_flag_decode u_decode (
        .alu_op (bus.ex_alu_op),
        .func   (bus.ex_func),
        .dec    (dec)
    );

    assign in_ld   = (state_q == ST_LDPEND);
    assign cond_ok = (!dec.reads_c || carry_q) && (!dec.reads_z || zero_q);

    always_comb begin
        alu_ctrl   = ALU_NOP;
        ex_commit  = 1'b0;
        ex_stall   = 1'b0;
        ld_start   = 1'b0;
        skip       = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ld_err_d   = 1'b0;
        carry_d    = carry_q;
        zero_d     = zero_q;

        if (bus.ex_valid && !bus.flush) begin
            // Anything touching Z (or another load) must wait for the late Z.
            if (in_ld && (bus.ex_is_load || dec.reads_z || dec.writes_z)) begin
                ex_stall = 1'b1;
            end else if (bus.ex_is_load) begin
                ex_commit = 1'b1;
                alu_ctrl  = ALU_ADD;
                ld_start  = 1'b1;
            end else if (dec.cls != CLS_NONE) begin
                if (cond_ok) begin
                    ex_commit = 1'b1;
                    alu_ctrl  = class_ctrl(dec.cls);
                end else begin
                    skip = 1'b1;
                end
            end
        end

        if (ex_commit && !bus.ex_is_load) begin
            if (dec.writes_c) carry_d = bus.alu_carry;
            if (dec.writes_z) zero_d  = bus.alu_zero;
        end

        case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d    = ST_LDPEND;
                    wait_cnt_d = '0;
                end
            end
            ST_LDPEND: begin
                if (bus.mem_ld_valid) begin
                    state_d = ST_IDLE;
                    zero_d  = bus.mem_ld_zero;
                end else if (wait_cnt_q == TW'(LD_TIMEOUT - 1)) begin
                    state_d  = ST_IDLE;
                    ld_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            ld_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            ld_err_q   <= ld_err_d;
        end
    end

`ifdef ALU_SCHED_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        skip_cnt_d  = skip_cnt_q;
        if (ex_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (skip && (skip_cnt_q != '1))      skip_cnt_d  = skip_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            skip_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            skip_cnt_q  <= skip_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_skip_cnt  = skip_cnt_q;
`else
    logic [CNT_W-1:0] perf_unused;
    logic             skip_unused;
    assign perf_unused = '0;
    assign skip_unused = skip;
`endif

    assign bus.alu_ctrl  = alu_ctrl;
    assign bus.ex_commit = ex_commit;
    assign bus.ex_stall  = ex_stall;
    assign bus.carry_q   = carry_q;
    assign bus.zero_q    = zero_q;
    assign bus.ld_err    = ld_err_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_alu_flag_sched.sv
// Directed + randomized bench for alu_flag_sched with an output scoreboard queue.
module tb_alu_flag_sched;
  import alu_flag_sched_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [4:0] exp_q[$];  // {ctrl_care, alu_ctrl, ex_commit, ex_stall}

  alu_flag_sched_if bus();

`ifdef ALU_SCHED_PERF_EN
  logic [15:0] perf_stall_cnt, perf_skip_cnt;
`endif

  alu_flag_sched #(.LD_TIMEOUT(15), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef ALU_SCHED_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_skip_cnt  (perf_skip_cnt),
`endif
    .bus            (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one EX cycle: drive after the edge, push expectation, sample at negedge
  task automatic step(input logic v, input logic [5:0] opf, input logic ld,
                      input logic ac, input logic az, input logic mv, input logic mz,
                      input logic fl, input logic care, input logic [1:0] ctrl,
                      input logic commit, input logic stall);
    logic [4:0] e;
    logic [4:0] obs;
    @(posedge clk);
    #1;
    bus.ex_valid     = v;
    bus.ex_alu_op    = opf[5:2];
    bus.ex_func      = opf[1:0];
    bus.ex_is_load   = ld;
    bus.alu_carry    = ac;
    bus.alu_zero     = az;
    bus.mem_ld_valid = mv;
    bus.mem_ld_zero  = mz;
    bus.flush        = fl;
    exp_q.push_back({care, care ? ctrl : 2'b00, commit, stall});
    @(negedge clk);
    e   = exp_q.pop_front();
    obs = {e[4], bus.alu_ctrl & {2{e[4]}}, bus.ex_commit, bus.ex_stall};
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL outputs {care,ctrl,commit,stall} got %b expected %b at %0t", obs, e, $time);
    end
  endtask

  // registered state as seen during the current cycle
  task automatic check_regs(input logic ec, input logic ez, input state_e es, input logic eerr);
    n_tests++;
    assert (bus.carry_q === ec) else begin
      n_fail++;
      $error("FAIL carry_q got %b expected %b at %0t", bus.carry_q, ec, $time);
    end
    n_tests++;
    assert (bus.zero_q === ez) else begin
      n_fail++;
      $error("FAIL zero_q got %b expected %b at %0t", bus.zero_q, ez, $time);
    end
    n_tests++;
    assert (bus.dbg_state === es) else begin
      n_fail++;
      $error("FAIL state got %b expected %b at %0t", bus.dbg_state, es, $time);
    end
    n_tests++;
    assert (bus.ld_err === eerr) else begin
      n_fail++;
      $error("FAIL ld_err got %b expected %b at %0t", bus.ld_err, eerr, $time);
    end
  endtask

  localparam logic [5:0] OP_LW  = 6'b0100_00;
  localparam logic [5:0] OP_BAD = 6'b0011_00;
  localparam logic [5:0] OP_NDX = 6'b0010_11;
  localparam logic [5:0] OP_ADI = 6'b0000_10;

  initial begin
    int         k;
    logic       ac, az, take, wc, c_m, z_m;
    logic [5:0] opf;
    logic [1:0] ctl;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_alu_op = '0; bus.ex_func = '0; bus.ex_is_load = 1'b0;
    bus.alu_carry = 1'b0; bus.alu_zero = 1'b0; bus.mem_ld_valid = 1'b0;
    bus.mem_ld_zero = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    assert ({bus.alu_ctrl, bus.ex_commit, bus.ex_stall} === {ALU_NOP, 1'b0, 1'b0}) else begin
      n_fail++;
      $error("FAIL reset_outputs got %b%b%b expected 1000", bus.alu_ctrl, bus.ex_commit, bus.ex_stall);
    end
    check_regs(0, 0, ST_IDLE, 0);
    rst_n = 1'b1;

    // conditional resolve and zero-bubble forwarding
    step(1, OP_ADC, 0, 0, 0, 0, 0, 0, 1, ALU_NOP,  0, 0); check_regs(0, 0, ST_IDLE, 0);
    step(1, OP_ADD, 0, 1, 0, 0, 0, 0, 1, ALU_ADD,  1, 0); check_regs(0, 0, ST_IDLE, 0);
    step(1, OP_ADC, 0, 1, 1, 0, 0, 0, 1, ALU_ADD,  1, 0); check_regs(1, 0, ST_IDLE, 0);
    step(1, OP_NDC, 0, 0, 0, 0, 0, 0, 1, ALU_NAND, 1, 0); check_regs(1, 1, ST_IDLE, 0);
    step(1, OP_NDZ, 0, 0, 1, 0, 0, 0, 1, ALU_NOP,  0, 0); check_regs(1, 0, ST_IDLE, 0);
    step(1, OP_ADZ, 0, 0, 1, 0, 0, 0, 1, ALU_NOP,  0, 0); check_regs(1, 0, ST_IDLE, 0);
    step(1, OP_ADD, 0, 0, 1, 0, 0, 1, 1, ALU_NOP,  0, 0); check_regs(1, 0, ST_IDLE, 0);
    step(1, OP_BAD, 0, 0, 1, 0, 0, 0, 1, ALU_NOP,  0, 0); check_regs(1, 0, ST_IDLE, 0);
    step(1, OP_NDX, 0, 0, 1, 0, 0, 0, 1, ALU_NOP,  0, 0); check_regs(1, 0, ST_IDLE, 0);
    step(1, OP_ADI, 0, 0, 1, 0, 0, 0, 1, ALU_ADD,  1, 0); check_regs(1, 0, ST_IDLE, 0);
    step(0, OP_ADD, 0, 1, 0, 1, 0, 0, 1, ALU_NOP,  0, 0); check_regs(0, 1, ST_IDLE, 0);
    step(1, OP_ADL, 0, 1, 0, 0, 0, 0, 1, ALU_ADD,  1, 0); check_regs(0, 1, ST_IDLE, 0);

    // load then ADZ, Z returns two cycles after LW
    step(1, OP_LW,  1, 0, 0, 0, 0, 0, 0, ALU_NOP,  1, 0); check_regs(1, 0, ST_IDLE, 0);
    step(1, OP_ADZ, 0, 0, 1, 0, 0, 0, 1, ALU_NOP,  0, 1); check_regs(1, 0, ST_LDPEND, 0);
    step(1, OP_ADZ, 0, 0, 1, 1, 1, 0, 1, ALU_NOP,  0, 1); check_regs(1, 0, ST_LDPEND, 0);
    step(1, OP_ADZ, 0, 0, 1, 0, 0, 0, 1, ALU_ADD,  1, 0); check_regs(1, 1, ST_IDLE, 0);

    // load with no return: timeout after 15 LDPEND cycles
    step(1, OP_LW,  1, 0, 0, 0, 0, 0, 0, ALU_NOP,  1, 0); check_regs(0, 1, ST_IDLE, 0);
    for (int i = 0; i < 15; i++) begin
      step(1, OP_NDU, 0, 1, 0, 0, 0, 0, 1, ALU_NOP, 0, 1); check_regs(0, 1, ST_LDPEND, 0);
    end
    step(1, OP_NDU, 0, 1, 0, 0, 0, 0, 1, ALU_NAND, 1, 0); check_regs(0, 1, ST_IDLE, 1);
    step(0, OP_NDU, 0, 0, 0, 0, 0, 0, 1, ALU_NOP,  0, 0); check_regs(0, 0, ST_IDLE, 0);

    // flush of a stalled ADZ keeps the pending load
    step(1, OP_LW,  1, 0, 0, 0, 0, 0, 0, ALU_NOP,  1, 0); check_regs(0, 0, ST_IDLE, 0);
    step(1, OP_ADZ, 0, 0, 0, 0, 0, 0, 1, ALU_NOP,  0, 1); check_regs(0, 0, ST_LDPEND, 0);
    step(1, OP_ADZ, 0, 0, 0, 0, 0, 1, 1, ALU_NOP,  0, 0); check_regs(0, 0, ST_LDPEND, 0);
    step(1, OP_ADZ, 0, 0, 0, 1, 1, 0, 1, ALU_NOP,  0, 1); check_regs(0, 0, ST_LDPEND, 0);
    step(1, OP_ADZ, 0, 1, 0, 0, 0, 0, 1, ALU_ADD,  1, 0); check_regs(0, 1, ST_IDLE, 0);
    step(1, OP_ADD, 0, 1, 1, 0, 0, 0, 1, ALU_ADD,  1, 0); check_regs(1, 0, ST_IDLE, 0);

    // asynchronous reset in the middle of LDPEND
    step(1, OP_LW,  1, 0, 0, 0, 0, 0, 0, ALU_NOP,  1, 0); check_regs(1, 1, ST_IDLE, 0);
    step(1, OP_ADZ, 0, 1, 1, 0, 0, 0, 1, ALU_NOP,  0, 1); check_regs(1, 1, ST_LDPEND, 0);
    #1 rst_n = 1'b0;
    #1 check_regs(0, 0, ST_IDLE, 0);
    #1 rst_n = 1'b1;
    step(1, OP_ADZ, 0, 1, 1, 0, 0, 0, 1, ALU_NOP,  0, 0); check_regs(0, 0, ST_IDLE, 0);

    // randomized unconditional/conditional ops against a flag model
    c_m = 1'b0;
    z_m = 1'b0;
    for (int i = 0; i < 24; i++) begin
      k  = $urandom_range(0, 5);
      ac = 1'($urandom_range(0, 1));
      az = 1'($urandom_range(0, 1));
      case (k)
        0:       begin opf = OP_ADD; take = 1'b1; ctl = ALU_ADD;  wc = 1'b1; end
        1:       begin opf = OP_ADC; take = c_m;  ctl = ALU_ADD;  wc = 1'b1; end
        2:       begin opf = OP_ADZ; take = z_m;  ctl = ALU_ADD;  wc = 1'b1; end
        3:       begin opf = OP_NDU; take = 1'b1; ctl = ALU_NAND; wc = 1'b0; end
        4:       begin opf = OP_NDC; take = c_m;  ctl = ALU_NAND; wc = 1'b0; end
        default: begin opf = OP_NDZ; take = z_m;  ctl = ALU_NAND; wc = 1'b0; end
      endcase
      step(1, opf, 0, ac, az, 0, 0, 0, 1, take ? ctl : ALU_NOP, take, 0);
      check_regs(c_m, z_m, ST_IDLE, 0);
      if (take) begin
        if (wc) c_m = ac;
        z_m = az;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_flag_sched.md
# alu_flag_sched

Execute-stage scheduler for the shared ALU and the architectural carry/zero flags. It decodes the EX instruction's ALUOp/function into the 2-bit ALU control, resolves conditional ops (ADC/ADZ/NDC/NDZ) against the live flags, and owns the C/Z flag registers. It also interlocks EX against an in-flight load whose Z result arrives late from MEM. The block sits between the ID/EX pipeline register and the ALU, and drives the EX stall and commit (write-enable) signals.

## Interface
- LD_TIMEOUT, 15: maximum cycles spent in LDPEND before forced exit with error.
- CNT_W, 16: width of the perf counters; used only with ALU_SCHED_PERF_EN.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  a valid instruction occupies EX.
- ex_alu_op  in  4  ALUOp field of the EX instruction.
- ex_func  in  2  function field of the EX instruction.
- ex_is_load  in  1  the EX instruction is LW; its Z flag is produced in MEM.
- alu_carry, alu_zero  in  1 each  same-cycle ALU result flags.
- mem_ld_valid  in  1  the load result is valid in MEM this cycle.
- mem_ld_zero  in  1  the load result equals zero.
- flush  in  1  squash the EX instruction this cycle.
- alu_ctrl  out  2  ALU control: 00 ADD, 01 NAND, 10 NOP.
- ex_commit  out  1  the EX instruction executes; gates register writeback.
- ex_stall  out  1  hold EX and all upstream stages.
- carry_q, zero_q  out  1 each  architectural flags.
- ld_err  out  1  one-cycle pulse when the LDPEND timeout fires.

## Operation
- Decode on {ex_alu_op, ex_func}:
  - 0001_00 ADD, 0001_11 ADL, 0000_xx ADI: add, unconditional.
  - 0001_10 ADC: add if carry_q, else skip.
  - 0001_01 ADZ: add if zero_q, else skip.
  - 0010_00 NDU: nand, unconditional.
  - 0010_10 NDC: nand if carry_q, else skip.
  - 0010_01 NDZ: nand if zero_q, else skip.
  - Anything else: NOP, with ex_commit=0.
- Skip: alu_ctrl=10, ex_commit=0, no flag write.
- Flag writes on a committed op:
  - Add-class ops write C<=alu_carry and Z<=alu_zero.
  - Nand-class ops write Z only.
- Load: when ex_valid & ex_is_load & !ex_stall & !flush, ex_commit=1 and the FSM enters LDPEND. The flags are untouched in EX.
- FSM states are IDLE and LDPEND.
  - LDPEND → IDLE when mem_ld_valid; Z<=mem_ld_zero at that edge.
  - LDPEND → IDLE when the wait counter reaches LD_TIMEOUT; ld_err pulses and Z is unchanged.
  - The wait counter clears on entry to LDPEND.
- Interlock: in LDPEND, ex_stall=1 if ex_valid and the EX op reads Z (ADZ, NDZ), writes Z (any add/nand-class op), or is a load. While stalled, alu_ctrl=10 and ex_commit=0.
- flush: forces ex_commit=0, ex_stall=0 and alu_ctrl=10, and suppresses flag writes. The pending load is older than the flushed instruction, so LDPEND is kept.
- ex_valid=0: alu_ctrl=10, ex_commit=0, ex_stall=0.

## Timing
- Reset values: carry_q=0, zero_q=0, ld_err=0, FSM=IDLE, counters=0. Combinational outputs with ex_valid=0 are alu_ctrl=10, ex_commit=0, ex_stall=0.
- alu_ctrl, ex_commit and ex_stall are combinational from the inputs and registered state. The flags are registered.
- Flag forwarding has zero bubbles: an op in cycle N+1 sees the flags written by the op committed in cycle N.
- mem_ld_valid in the same cycle as a stalled ADZ: the stall still holds that cycle. ADZ evaluates the new Z in the next cycle, so the load-to-use penalty is at least one stall cycle.
- mem_ld_valid while in IDLE is ignored.
- rst_n asserted mid-LDPEND: immediate return to IDLE; the pending load's Z is dropped.

## Configuration
- ALU_SCHED_PERF_EN defined:
  - Adds outputs perf_stall_cnt [CNT_W] and perf_skip_cnt [CNT_W].
  - perf_stall_cnt counts cycles with ex_stall=1; perf_skip_cnt counts conditional ops skipped on a false flag.
  - Both counters saturate at all-ones and reset to 0.
- ALU_SCHED_PERF_EN undefined: the ports and logic are absent.

## Structure
- Shared package holds:
  - the 6-bit decode constants;
  - the ALU control encodings ALU_ADD=00, ALU_NAND=01, ALU_NOP=10;
  - the FSM state typedef.
- One sub-module, alu_flag_decode: purely combinational decode of {ex_alu_op, ex_func} into op class and flag read/write masks. The top level holds the FSM, the flag registers and the counters.

## Test plan
- After reset, ADC with carry_q=0 → alu_ctrl=10, ex_commit=0, flags stay 0.
- ADD producing alu_carry=1, then ADC in the next cycle → ADC gives alu_ctrl=00, ex_commit=1 with no stall.
- LW, then ADZ; mem_ld_valid with mem_ld_zero=1 two cycles later → ADZ stalls 2 cycles, then commits with alu_ctrl=00, and zero_q=1 before it executes.
- LW, then NDU, with no mem_ld_valid → NDU stalls; after 15 cycles ld_err pulses once, the FSM returns to IDLE and NDU commits.
- Stalled ADZ in LDPEND with flush=1 → ex_stall=0, ex_commit=0, FSM stays LDPEND; a later mem_ld_valid updates Z.
- rst_n low during LDPEND → FSM IDLE and flags 0 immediately; a following ADZ with no load pending is skipped (Z=0) without stalling.
